servant_mem_arbiter: RTL and testbench

- Three-master to one-slave Wishbone arbiter that shares the single RAM port between three masters: CPU instruction bus (ibus), CPU data bus after address decode (dbus), and the debug module system-bus master (sbus).
- Uses round-robin arbitration. A grant is held for the whole transaction. Ibus requests are masked while the CPU is debug-halted.
- A bus-timeout watchdog completes any transaction the slave never acknowledges, so no master can hang the port.

---
 rtl/servant_mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_servant_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/servant_mem_arbiter.sv
// rtl/servant_mem_arbiter.sv - round-robin three-master Wishbone arbiter with bus-timeout watchdog
module servant_mem_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_dbg_halt,
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    input  logic [31:0] i_sbus_adr,
    input  logic [31:0] i_sbus_dat,
    input  logic [3:0]  i_sbus_sel,
    input  logic        i_sbus_we,
    input  logic        i_sbus_cyc,
    output logic [31:0] o_sbus_rdt,
    output logic        o_sbus_ack,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_dat,
    output logic [3:0]  o_mem_sel,
    output logic        o_mem_we,
    output logic        o_mem_cyc,
    input  logic [31:0] i_mem_rdt,
    input  logic        i_mem_ack,
    output logic [2:0]  o_grant,
    output logic        o_timeout
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_BUSY = 1'b1;

    localparam logic          TO_EN    = (TIMEOUT > 0);
    localparam logic [TW-1:0] CNT_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    logic          state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic [2:0]    last_q, last_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [2:0]    req;
    logic [2:0]    pick;
    logic          busy;
    logic          timeout_hit;
    logic          done;
    logic          data_ok;

    assign req = {i_sbus_cyc, i_dbus_cyc, i_ibus_cyc & ~i_dbg_halt};

    // First requester strictly after the last-granted master, cyclic ibus -> dbus -> sbus.
    always_comb begin
        pick = 3'b000;
        case (last_q)
            3'b001: begin
                if (req[1])      pick = 3'b010;
                else if (req[2]) pick = 3'b100;
                else if (req[0]) pick = 3'b001;
            end
            3'b010: begin
                if (req[2])      pick = 3'b100;
                else if (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
            end
            default: begin
                if (req[0])      pick = 3'b001;
                else if (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
            end
        endcase
    end

    assign busy        = (state_q == STATE_BUSY);
    assign timeout_hit = TO_EN & busy & ~i_mem_ack & (cnt_q == CNT_LAST) & ~i_rst;
    assign done        = busy & (i_mem_ack | timeout_hit) & ~i_rst;
    assign data_ok     = busy & i_mem_ack & ~i_rst;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (!busy) begin
            if (pick != 3'b000) begin
                state_d = STATE_BUSY;
                grant_d = pick;
                last_d  = pick;
                cnt_d   = '0;
            end
        end else if (done) begin
            state_d = STATE_IDLE;
            grant_d = 3'b000;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= STATE_IDLE;
            grant_q <= 3'b000;
            last_q  <= 3'b100;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // grant_q is zero in IDLE, so the slave outputs fall to zero there.
    always_comb begin
        o_mem_adr = 32'h0;
        o_mem_dat = 32'h0;
        o_mem_sel = 4'h0;
        o_mem_we  = 1'b0;
        if (grant_q[0]) begin
            o_mem_adr = i_ibus_adr;
            o_mem_sel = 4'hF;
        end else if (grant_q[1]) begin
            o_mem_adr = i_dbus_adr;
            o_mem_dat = i_dbus_dat;
            o_mem_sel = i_dbus_sel;
            o_mem_we  = i_dbus_we;
        end else if (grant_q[2]) begin
            o_mem_adr = i_sbus_adr;
            o_mem_dat = i_sbus_dat;
            o_mem_sel = i_sbus_sel;
            o_mem_we  = i_sbus_we;
        end
    end

    assign o_mem_cyc  = busy;
    assign o_grant    = grant_q;
    assign o_timeout  = timeout_hit;

    assign o_ibus_ack = done & grant_q[0];
    assign o_dbus_ack = done & grant_q[1];
    assign o_sbus_ack = done & grant_q[2];

    assign o_ibus_rdt = (data_ok & grant_q[0]) ? i_mem_rdt : 32'h0;
    assign o_dbus_rdt = (data_ok & grant_q[1]) ? i_mem_rdt : 32'h0;
    assign o_sbus_rdt = (data_ok & grant_q[2]) ? i_mem_rdt : 32'h0;

endmodule

// File: tb/tb_servant_mem_arbiter.sv
// tb/tb_servant_mem_arbiter.sv - directed self-checking bench for servant_mem_arbiter
module tb_servant_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        dbg_halt;
    logic [31:0] ibus_adr;
    logic        ibus_cyc;
    logic [31:0] ibus_rdt;
    logic        ibus_ack;
    logic [31:0] dbus_adr, dbus_dat;
    logic [3:0]  dbus_sel;
    logic        dbus_we, dbus_cyc;
    logic [31:0] dbus_rdt;
    logic        dbus_ack;
    logic [31:0] sbus_adr, sbus_dat;
    logic [3:0]  sbus_sel;
    logic        sbus_we, sbus_cyc;
    logic [31:0] sbus_rdt;
    logic        sbus_ack;
    logic [31:0] mem_adr, mem_dat;
    logic [3:0]  mem_sel;
    logic        mem_we, mem_cyc;
    logic [31:0] mem_rdt;
    logic        mem_ack;
    logic [2:0]  grant;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    servant_mem_arbiter #(.TIMEOUT(4), .TW(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_dbg_halt(dbg_halt),
        .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc),
        .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack),
        .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel),
        .i_dbus_we(dbus_we), .i_dbus_cyc(dbus_cyc),
        .o_dbus_rdt(dbus_rdt), .o_dbus_ack(dbus_ack),
        .i_sbus_adr(sbus_adr), .i_sbus_dat(sbus_dat), .i_sbus_sel(sbus_sel),
        .i_sbus_we(sbus_we), .i_sbus_cyc(sbus_cyc),
        .o_sbus_rdt(sbus_rdt), .o_sbus_ack(sbus_ack),
        .o_mem_adr(mem_adr), .o_mem_dat(mem_dat), .o_mem_sel(mem_sel),
        .o_mem_we(mem_we), .o_mem_cyc(mem_cyc),
        .i_mem_rdt(mem_rdt), .i_mem_ack(mem_ack),
        .o_grant(grant), .o_timeout(timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; callers then drive inputs and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ibus_cyc = 1'b0; dbus_cyc = 1'b0; sbus_cyc = 1'b0;
        mem_ack = 1'b0;  dbg_halt = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; dbg_halt = 1'b0;
        ibus_adr = 32'h0; ibus_cyc = 1'b0;
        dbus_adr = 32'h0; dbus_dat = 32'h0; dbus_sel = 4'h0; dbus_we = 1'b0; dbus_cyc = 1'b0;
        sbus_adr = 32'h0; sbus_dat = 32'h0; sbus_sel = 4'h0; sbus_we = 1'b0; sbus_cyc = 1'b0;
        mem_rdt = 32'h0; mem_ack = 1'b0;

        do_reset();
        settle();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_cyc", 32'(mem_cyc), 32'h0);
        check("rst_acks", {29'h0, sbus_ack, dbus_ack, ibus_ack}, 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);

        // Single dbus write, slave acks in the first BUSY cycle.
        dbus_adr = 32'h100; dbus_dat = 32'hA5A5A5A5; dbus_sel = 4'hF; dbus_we = 1'b1; dbus_cyc = 1'b1;
        settle();
        check("dw_req_grant", 32'(grant), 32'h0);
        tick();
        mem_ack = 1'b1; mem_rdt = 32'h1234_5678;
        settle();
        check("dw_grant", 32'(grant), 32'h2);
        check("dw_adr", mem_adr, 32'h100);
        check("dw_dat", mem_dat, 32'hA5A5A5A5);
        check("dw_sel", 32'(mem_sel), 32'hF);
        check("dw_we", 32'(mem_we), 32'h1);
        check("dw_cyc", 32'(mem_cyc), 32'h1);
        check("dw_ack", {29'h0, sbus_ack, dbus_ack, ibus_ack}, 32'h2);
        tick();
        dbus_cyc = 1'b0; mem_ack = 1'b0;
        settle();
        check("dw_cyc_after", 32'(mem_cyc), 32'h0);
        check("dw_grant_after", 32'(grant), 32'h0);

        // All three request continuously from reset: round-robin ibus, dbus, sbus, ...
        do_reset();
        ibus_cyc = 1'b1; dbus_cyc = 1'b1; sbus_cyc = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic [2:0] exp_g;
            exp_g = (i % 3 == 0) ? 3'b001 : (i % 3 == 1) ? 3'b010 : 3'b100;
            tick();
            mem_ack = 1'b1;
            settle();
            check($sformatf("rr_grant%0d", i), 32'(grant), 32'(exp_g));
            check($sformatf("rr_ack%0d", i), {29'h0, sbus_ack, dbus_ack, ibus_ack}, 32'(exp_g));
            tick();
            mem_ack = 1'b0;
            settle();
        end
        ibus_cyc = 1'b0; dbus_cyc = 1'b0; sbus_cyc = 1'b0;

        // ibus read: fixed write-enable/select, data only to ibus.
        do_reset();
        ibus_adr = 32'h200; ibus_cyc = 1'b1;
        dbus_dat = 32'hFFFF_0000; dbus_we = 1'b1;
        tick();
        mem_ack = 1'b1; mem_rdt = 32'h0000_0013;
        settle();
        check("ir_grant", 32'(grant), 32'h1);
        check("ir_rdt", ibus_rdt, 32'h13);
        check("ir_ack", 32'(ibus_ack), 32'h1);
        check("ir_we", 32'(mem_we), 32'h0);
        check("ir_sel", 32'(mem_sel), 32'hF);
        check("ir_dat", mem_dat, 32'h0);
        check("ir_adr", mem_adr, 32'h200);
        check("ir_dbus_rdt", dbus_rdt, 32'h0);
        check("ir_sbus_rdt", sbus_rdt, 32'h0);
        tick();
        ibus_cyc = 1'b0; mem_ack = 1'b0;

        // Debug halt masks ibus; it is served one cycle after halt drops.
        do_reset();
        dbg_halt = 1'b1; ibus_cyc = 1'b1; sbus_cyc = 1'b1; sbus_adr = 32'h300;
        tick();
        mem_ack = 1'b1;
        settle();
        check("dh_grant", 32'(grant), 32'h4);
        check("dh_ibus_ack", 32'(ibus_ack), 32'h0);
        tick();
        sbus_cyc = 1'b0; mem_ack = 1'b0;
        tick();
        settle();
        check("dh_idle_grant", 32'(grant), 32'h0);
        check("dh_idle_cyc", 32'(mem_cyc), 32'h0);
        dbg_halt = 1'b0;
        settle();
        check("dh_release_grant", 32'(grant), 32'h0);
        tick();
        mem_ack = 1'b1;
        settle();
        check("dh_ibus_grant", 32'(grant), 32'h1);
        check("dh_ibus_ack2", 32'(ibus_ack), 32'h1);
        tick();
        ibus_cyc = 1'b0; mem_ack = 1'b0;

        // Watchdog: sbus never acked; pending dbus served afterwards.
        sbus_cyc = 1'b1; mem_rdt = 32'hDEAD_BEEF;
        tick();
        dbus_cyc = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            settle();
            check($sformatf("to_wait_grant%0d", i), 32'(grant), 32'h4);
            check($sformatf("to_wait_flag%0d", i), {30'h0, timeout, sbus_ack}, 32'h0);
            tick();
        end
        settle();
        check("to_sbus_ack", 32'(sbus_ack), 32'h1);
        check("to_pulse", 32'(timeout), 32'h1);
        check("to_sbus_rdt", sbus_rdt, 32'h0);
        tick();
        sbus_cyc = 1'b0;
        settle();
        check("to_idle_grant", 32'(grant), 32'h0);
        check("to_idle_pulse", 32'(timeout), 32'h0);
        tick();
        mem_ack = 1'b1; mem_rdt = 32'h0000_00AA;
        settle();
        check("to_dbus_grant", 32'(grant), 32'h2);
        check("to_dbus_rdt", dbus_rdt, 32'hAA);
        tick();
        dbus_cyc = 1'b0; mem_ack = 1'b0;

        // Ack arriving on the last watchdog cycle is a normal completion.
        sbus_cyc = 1'b1;
        tick();
        tick();
        tick();
        tick();
        mem_ack = 1'b1; mem_rdt = 32'h0000_0055;
        settle();
        check("tr_grant", 32'(grant), 32'h4);
        check("tr_ack", 32'(sbus_ack), 32'h1);
        check("tr_pulse", 32'(timeout), 32'h0);
        check("tr_rdt", sbus_rdt, 32'h55);
        tick();
        sbus_cyc = 1'b0; mem_ack = 1'b0;

        // Reset in BUSY abandons the transaction; ibus regains first priority.
        dbus_cyc = 1'b1;
        tick();
        settle();
        check("mr_busy_grant", 32'(grant), 32'h2);
        rst = 1'b1;
        settle();
        check("mr_no_ack_rst", 32'(dbus_ack), 32'h0);
        tick();
        rst = 1'b0;
        settle();
        check("mr_cyc", 32'(mem_cyc), 32'h0);
        check("mr_grant", 32'(grant), 32'h0);
        check("mr_no_ack", {29'h0, sbus_ack, dbus_ack, ibus_ack}, 32'h0);
        ibus_cyc = 1'b1;
        tick();
        settle();
        check("mr_ibus_first", 32'(grant), 32'h1);
        mem_ack = 1'b1;
        tick();
        ibus_cyc = 1'b0; dbus_cyc = 1'b0; mem_ack = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
